// File: rtl/base_edemux_buf.sv
// base_edemux_buf: buffered encoded-select demultiplexer steering one valid/ready stream to `ways` outputs
//   clk, reset   clock and synchronous active-high reset
//   i_v, i_r     input beat handshake
//   i_sel        encoded destination of the input beat, MSB at index 0
//   i_d          input data
//   o_v, o_r     per-way handshake; o_v is one-hot or zero, bit 0 = way 0
//   o_d          head data shared by all ways, meaningful only when |o_v
//   o_drop       one-cycle pulse when an out-of-range head beat is discarded
module base_edemux_buf #(
   parameter int width = 1,
   parameter int ways = 2,
   parameter int sel_width = $clog2(ways)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_v,
   output logic                 i_r,
   input  logic [0:sel_width-1] i_sel,
   input  logic [0:width-1]     i_d,
   output logic [0:ways-1]      o_v,
   input  logic [0:ways-1]      o_r,
   output logic [0:width-1]     o_d,
   output logic                 o_drop
);
   logic [sel_width-1:0] m_sel [0:1];
   logic [width-1:0]     m_d [0:1];
   logic                 head, tail, push, pop;
   logic [1:0]           count;
   logic [sel_width-1:0] h_sel;
   assign h_sel = m_sel[head];
   assign o_d = m_d[head];
   // ready depends only on registered occupancy, never on o_r
   assign i_r = !reset && count != 2'd2;
   assign push = i_v && i_r;
   always_comb begin
      o_v = '0;
      for (int w = 0; w < ways; w++) o_v[w] = count != 2'd0 && 32'(h_sel) == 32'(w);
   end
   // an out-of-range head has no destination, so it leaves the buffer on its own
   assign o_drop = count != 2'd0 && 32'(h_sel) >= 32'(ways);
   assign pop = |(o_v & o_r) || o_drop;
   always_ff @(posedge clk)
      if (push) begin
         m_sel[tail] <= i_sel;
         m_d[tail] <= i_d;
      end
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         head <= 1'b0;
         tail <= 1'b0;
      end else begin
         if (push) tail <= !tail;
         if (pop) head <= !head;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: tb/tb_base_edemux_buf.sv
// tb_base_edemux_buf: checks a 4-way and a 3-way instance against a queue-based reference model
module tb_base_edemux_buf;
   typedef struct {
      int sel;
      int d;
   } beat_t;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       i_v = 1'b0;
   logic [0:1] i_sel = '0;
   logic [0:7] i_d = '0;
   logic [0:3] o_r = '0;
   logic       i_r4, i_r3, o_drop4, o_drop3;
   logic [0:3] o_v4;
   logic [0:2] o_v3;
   logic [0:7] o_d4, o_d3;
   beat_t      q4[$];
   beat_t      q3[$];
   int         tests = 0;
   int         fails = 0;
   base_edemux_buf #(.width(8), .ways(4)) u4 (
      .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r4), .i_sel(i_sel), .i_d(i_d),
      .o_v(o_v4), .o_r(o_r), .o_d(o_d4), .o_drop(o_drop4)
   );
   base_edemux_buf #(.width(8), .ways(3), .sel_width(2)) u3 (
      .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r3), .i_sel(i_sel), .i_d(i_d),
      .o_v(o_v3), .o_r(o_r[0:2]), .o_d(o_d3), .o_drop(o_drop3)
   );
   always #5 clk = ~clk;
   // expected {i_r, o_v[0:3], o_drop, o_d (zero unless a way is valid)} from the queue contents
   function automatic logic [13:0] expv(beat_t q[$], int ways);
      logic [0:3] v;
      logic [7:0] d;
      logic       dr;
      v = '0;
      d = '0;
      dr = 1'b0;
      if (q.size() > 0) begin
         if (q[0].sel < ways) begin
            v[q[0].sel] = 1'b1;
            d = 8'(q[0].d);
         end else dr = 1'b1;
      end
      return {!reset && q.size() < 2, v, dr, d};
   endfunction
   function automatic logic [13:0] act4();
      return {i_r4, o_v4, o_drop4, (|o_v4) ? o_d4 : 8'h00};
   endfunction
   function automatic logic [13:0] act3();
      return {i_r3, o_v3, 1'b0, o_drop3, (|o_v3) ? o_d3 : 8'h00};
   endfunction
   // one clock: model consumes the same inputs the DUTs see at the edge, then outputs are sampled at negedge
   task automatic tick();
      bit p4, p3, d4, d3;
      p4 = i_v && !reset && q4.size() < 2;
      p3 = i_v && !reset && q3.size() < 2;
      d4 = q4.size() > 0 && (q4[0].sel >= 4 || o_r[q4[0].sel] === 1'b1);
      d3 = q3.size() > 0 && (q3[0].sel >= 3 || o_r[q3[0].sel] === 1'b1);
      @(posedge clk);
      if (reset) begin
         q4.delete();
         q3.delete();
      end else begin
         if (d4) void'(q4.pop_front());
         if (d3) void'(q3.pop_front());
         if (p4) q4.push_back('{int'(i_sel), int'(i_d)});
         if (p3) q3.push_back('{int'(i_sel), int'(i_d)});
      end
      @(negedge clk);
   endtask
   task automatic test_reset();
      reset = 1'b1;
      i_v = 1'b1;
      for (int k = 0; k < 3; k++) begin
         i_sel = 2'($urandom);
         i_d = 8'($urandom);
         tick();
         tests++;
         if ({i_r4, o_v4, o_drop4, i_r3, o_v3, o_drop3} !== 11'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 0", {i_r4, o_v4, o_drop4, i_r3, o_v3, o_drop3});
         end
      end
      reset = 1'b0;
      i_v = 1'b0;
      tick();
      tests++;
      if ({i_r4, i_r3} !== 2'b11) begin
         fails++;
         $display("FAIL reset_release: i_r got %b expected 11", {i_r4, i_r3});
      end
   endtask
   task automatic test_streaming();
      o_r = 4'b1111;
      i_v = 1'b1;
      i_sel = 2'd2;
      i_d = 8'hA5;
      tick();
      tests++;
      if (o_v4 !== 4'b0010 || o_d4 !== 8'hA5) begin
         fails++;
         $display("FAIL stream_first: got v=%b d=%h expected v=0010 d=a5", o_v4, o_d4);
      end
      i_sel = 2'd0;
      i_d = 8'h3C;
      tick();
      tests++;
      if (o_v4 !== 4'b1000 || o_d4 !== 8'h3C) begin
         fails++;
         $display("FAIL stream_second: got v=%b d=%h expected v=1000 d=3c", o_v4, o_d4);
      end
      i_v = 1'b0;
      tick();
      tests++;
      if ({act4(), act3()} !== {expv(q4, 4), expv(q3, 3)}) begin
         fails++;
         $display("FAIL stream_drain: got %h expected %h", {act4(), act3()}, {expv(q4, 4), expv(q3, 3)});
      end
   endtask
   task automatic test_backpressure();
      o_r = 4'b0000;
      i_v = 1'b1;
      i_sel = 2'd1;
      for (int k = 0; k < 7; k++) begin
         if (k == 3) o_r = 4'b0100;
         if (k == 5) i_v = 1'b0;
         i_d = 8'($urandom);
         tick();
         tests++;
         if ({act4(), act3()} !== {expv(q4, 4), expv(q3, 3)}) begin
            fails++;
            $display("FAIL backpressure cyc %0d: got %h expected %h", k, {act4(), act3()}, {expv(q4, 4), expv(q3, 3)});
         end
         if (k == 1 || k == 2 || k == 3) begin
            tests++;
            if (i_r4 !== (k == 3)) begin
               fails++;
               $display("FAIL backpressure_ready cyc %0d: got %b expected %b", k, i_r4, k == 3);
            end
         end
      end
   endtask
   task automatic test_out_of_range();
      o_r = 4'b1111;
      i_v = 1'b1;
      i_sel = 2'd3;
      i_d = 8'h11;
      tick();
      tests++;
      if (o_drop3 !== 1'b1 || o_v3 !== 3'b000 || o_v4 !== 4'b0001) begin
         fails++;
         $display("FAIL oor_drop: got drop=%b v3=%b v4=%b expected drop=1 v3=000 v4=0001", o_drop3, o_v3, o_v4);
      end
      i_sel = 2'd1;
      i_d = 8'h22;
      tick();
      tests++;
      if (o_drop3 !== 1'b0 || o_v3 !== 3'b010 || o_d3 !== 8'h22) begin
         fails++;
         $display("FAIL oor_next: got drop=%b v=%b d=%h expected drop=0 v=010 d=22", o_drop3, o_v3, o_d3);
      end
      i_v = 1'b0;
      tick();
   endtask
   task automatic test_head_of_line();
      o_r = 4'b1000;
      i_v = 1'b1;
      i_sel = 2'd1;
      i_d = 8'($urandom);
      tick();
      i_sel = 2'd0;
      i_d = 8'($urandom);
      tick();
      i_v = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k == 3) o_r = 4'b1100;
         tick();
         tests++;
         if ({act4(), act3()} !== {expv(q4, 4), expv(q3, 3)}) begin
            fails++;
            $display("FAIL hol cyc %0d: got %h expected %h", k, {act4(), act3()}, {expv(q4, 4), expv(q3, 3)});
         end
         if (k < 3) begin
            tests++;
            if (o_v4 !== 4'b0100 || o_v3 !== 3'b010) begin
               fails++;
               $display("FAIL hol_blocked cyc %0d: got v4=%b v3=%b expected 0100/010", k, o_v4, o_v3);
            end
         end
      end
   endtask
   task automatic test_reset_mid_op();
      o_r = 4'b0000;
      i_v = 1'b1;
      for (int k = 0; k < 2; k++) begin
         i_sel = 2'($urandom);
         i_d = 8'($urandom);
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      i_v = 1'b0;
      tests++;
      if ({o_v4, o_v3, o_drop4, o_drop3} !== 9'b0) begin
         fails++;
         $display("FAIL midreset_flush: got %b expected 0", {o_v4, o_v3, o_drop4, o_drop3});
      end
      o_r = 4'b1111;
      tick();
      tests++;
      if ({o_v4, o_v3, o_drop4, o_drop3, i_r4, i_r3} !== 11'b11) begin
         fails++;
         $display("FAIL midreset_idle: got %b expected 00000000011", {o_v4, o_v3, o_drop4, o_drop3, i_r4, i_r3});
      end
      i_v = 1'b1;
      i_sel = 2'd2;
      i_d = 8'h5A;
      tick();
      tests++;
      if (o_v4 !== 4'b0010 || o_d4 !== 8'h5A || o_v3 !== 3'b001 || o_d3 !== 8'h5A) begin
         fails++;
         $display("FAIL midreset_new: got v4=%b d4=%h v3=%b d3=%h expected 0010 5a 001 5a", o_v4, o_d4, o_v3, o_d3);
      end
      i_v = 1'b0;
      tick();
   endtask
   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         reset = $urandom_range(0, 63) == 0;
         i_v = $urandom_range(0, 3) != 0;
         i_sel = 2'($urandom);
         i_d = 8'($urandom);
         o_r = 4'($urandom) | ($urandom_range(0, 1) ? 4'hF : 4'h0);
         tick();
         tests++;
         if ({act4(), act3()} !== {expv(q4, 4), expv(q3, 3)}) begin
            fails++;
            $display("FAIL random cyc %0d: got %h expected %h", k, {act4(), act3()}, {expv(q4, 4), expv(q3, 3)});
         end
      end
      reset = 1'b0;
      i_v = 1'b0;
   endtask
   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_out_of_range();
      test_head_of_line();
      test_reset_mid_op();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
